// File: rtl/rf_access_seq_pkg.sv
// ---------------------------------------------------------------------------
// rf_access_seq_pkg
//   Shared definitions for the register-file access sequencer:
//   - instruction opcode / funct constants used by destination decode
//   - bit positions of the opcode, rs, rt, rd and funct fields
//   - FSM state encoding of the sequencer
//   Optional feature macro used by the design files: RF_R0_GUARD_EN.
// ---------------------------------------------------------------------------
package rf_access_seq_pkg;

  // Opcodes (INSTR[31:26]) that matter for write-back decode.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_JMP   = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_PUSH  = 6'h1b;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  // R-type funct (INSTR[5:0]) with no write-back.
  localparam logic [5:0] FUNCT_JR  = 6'h08;

  // jal links into this register.
  localparam logic [4:0] REG_LINK  = 5'd31;

  // Instruction field positions.
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_WB       = 3'd4
  } state_e;

endpackage

// File: rtl/rf_dest_decode.sv
// ---------------------------------------------------------------------------
// rf_dest_decode
//   Combinational write-back destination decode for one instruction.
//   Ports:
//     opcode [5:0] in  : INSTR[31:26]
//     funct  [5:0] in  : INSTR[5:0]
//     rt     [4:0] in  : INSTR[20:16]
//     rd     [4:0] in  : INSTR[15:11]
//     dest   [4:0] out : register to write back
//     wr_en        out : instruction writes the register file
//   Macro RF_R0_GUARD_EN: a destination of register 0 suppresses the write.
// ---------------------------------------------------------------------------
module rf_dest_decode
  import rf_access_seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [4:0] dest,
  output logic       wr_en
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    dest  = rt;
    wr_en = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        dest  = rd;
        wr_en = (funct != FUNCT_JR);
      end
      OPC_JAL:  dest = REG_LINK;
      OPC_JMP, OPC_BEQ, OPC_BNE, OPC_SW, OPC_PUSH: wr_en = 1'b0;
      default: ;
    endcase
`ifdef RF_R0_GUARD_EN
    // Register 0 is hard-wired; writing it is pointless, so skip WB.
    if (dest == 5'd0) wr_en = 1'b0;
`endif
  end

endmodule

// File: rtl/rf_access_seq.sv
// ---------------------------------------------------------------------------
// rf_access_seq
//   Register-file access sequencer. Accepts one instruction, reads rs/rt from
//   the register file, offers the operands to execute, waits for the result
//   and performs the write-back cycle.
//   Ports:
//     CLK, RST (sync, active-low)
//     INSTR_VALID/INSTR_READY/INSTR        : instruction handshake
//     OP_VALID/OP_READY/OP_A/OP_B/OP_INSTR : operand handshake to execute
//     RESULT_VALID/RESULT                  : execute result
//     RF_READ/RF_WRITE, RF_ADDR_R1/R2/W,
//     RF_DATA_W, RF_DATA_R1/R2             : register file controls and data
//   Macro RF_R0_GUARD_EN: no write-back to register 0, and operands read
//   from register 0 are forced to 0.
// ---------------------------------------------------------------------------
module rf_access_seq
  import rf_access_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic [31:0]        INSTR,
  output logic               OP_VALID,
  input  logic               OP_READY,
  output logic [DATA_W-1:0]  OP_A,
  output logic [DATA_W-1:0]  OP_B,
  output logic [31:0]        OP_INSTR,
  input  logic               RESULT_VALID,
  input  logic [DATA_W-1:0]  RESULT,
  output logic               RF_READ,
  output logic               RF_WRITE,
  output logic [RADDR_W-1:0] RF_ADDR_R1,
  output logic [RADDR_W-1:0] RF_ADDR_R2,
  output logic [RADDR_W-1:0] RF_ADDR_W,
  output logic [DATA_W-1:0]  RF_DATA_W,
  input  logic [DATA_W-1:0]  RF_DATA_R1,
  input  logic [DATA_W-1:0]  RF_DATA_R2
);

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  data_w_q, data_w_d;

  logic [4:0]         dec_dest;
  logic               dec_wr_en;
  logic [DATA_W-1:0]  rd1_val, rd2_val;

  // Decode straight from the offered instruction so the result can be
  // latched on the accept edge together with the instruction itself.
  rf_dest_decode u_dest_decode (
    .opcode (INSTR[OPC_MSB:OPC_LSB]),
    .funct  (INSTR[FUNCT_MSB:FUNCT_LSB]),
    .rt     (INSTR[RT_MSB:RT_LSB]),
    .rd     (INSTR[RD_MSB:RD_LSB]),
    .dest   (dec_dest),
    .wr_en  (dec_wr_en)
  );

  // Read addresses always follow the latched instruction; the register file
  // only acts on them while RF_READ is high.
  assign RF_ADDR_R1 = instr_q[RS_MSB:RS_LSB];
  assign RF_ADDR_R2 = instr_q[RT_MSB:RT_LSB];
  assign RF_ADDR_W  = dest_q;
  assign RF_DATA_W  = data_w_q;
  assign OP_A       = op_a_q;
  assign OP_B       = op_b_q;
  assign OP_INSTR   = instr_q;

`ifdef RF_R0_GUARD_EN
  assign rd1_val = (RF_ADDR_R1 == '0) ? '0 : RF_DATA_R1;
  assign rd2_val = (RF_ADDR_R2 == '0) ? '0 : RF_DATA_R2;
`else
  assign rd1_val = RF_DATA_R1;
  assign rd2_val = RF_DATA_R2;
`endif

  // ---- FSM: state register ------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---- FSM: next state ----------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (INSTR_VALID) state_d = ST_READ;
      ST_READ:     state_d = ST_ISSUE;
      ST_ISSUE:    if (OP_READY) state_d = ST_WAIT_RES;
      ST_WAIT_RES: if (RESULT_VALID) state_d = wr_en_q ? ST_WB : ST_IDLE;
      ST_WB:       state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs (Moore, from state only) ------------------------------
  always_comb begin
    INSTR_READY = 1'b0;
    RF_READ     = 1'b0;
    OP_VALID    = 1'b0;
    RF_WRITE    = 1'b0;
    case (state_q)
      ST_IDLE:  INSTR_READY = 1'b1;
      ST_READ:  RF_READ     = 1'b1;
      ST_ISSUE: OP_VALID    = 1'b1;
      ST_WB:    RF_WRITE    = 1'b1;
      default: ;
    endcase
  end

  // ---- Datapath next values -----------------------------------------------
  always_comb begin
    instr_d  = instr_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    dest_d   = dest_q;
    wr_en_d  = wr_en_q;
    data_w_d = data_w_q;

    if (state_q == ST_IDLE && INSTR_VALID) begin
      instr_d = INSTR;
      wr_en_d = dec_wr_en;
      // The write address only moves for instructions that will write, so
      // RF_ADDR_W keeps showing the last write target in between.
      if (dec_wr_en) dest_d = dec_dest;
    end

    // Read data is only driven during READ; capture it at the end of it.
    if (state_q == ST_READ) begin
      op_a_d = rd1_val;
      op_b_d = rd2_val;
    end

    if (state_q == ST_WAIT_RES && RESULT_VALID && wr_en_q) data_w_d = RESULT;
  end

  // ---- Datapath registers -------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: all datapath flops are reset because their values are visible
    // on ports and must read 0 after reset.
    if (!RST) begin
      instr_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      dest_q   <= '0;
      wr_en_q  <= 1'b0;
      data_w_q <= '0;
    end else begin
      instr_q  <= instr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      dest_q   <= dest_d;
      wr_en_q  <= wr_en_d;
      data_w_q <= data_w_d;
    end
  end

endmodule

// File: tb/tb_rf_access_seq.sv
// ---------------------------------------------------------------------------
// tb_rf_access_seq
//   Self-checking bench for rf_access_seq. A small register-file model sits
//   on the RF ports; expected operands and write-backs are queued when each
//   instruction is driven and popped when the DUT produces them.
//   Build with +define+RF_R0_GUARD_EN to exercise the register-0 guard.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rf_access_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] INSTR;
  logic        OP_VALID;
  logic        OP_READY;
  logic [31:0] OP_A, OP_B, OP_INSTR;
  logic        RESULT_VALID;
  logic [31:0] RESULT;
  logic        RF_READ, RF_WRITE;
  logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [31:0] RF_DATA_W;
  wire  [31:0] RF_DATA_R1, RF_DATA_R2;

`ifdef RF_R0_GUARD_EN
  localparam logic [31:0] R0_READ = 32'h0000_0000;
`else
  localparam logic [31:0] R0_READ = 32'hDEAD_0000;
`endif

  rf_access_seq #(.DATA_W(32), .RADDR_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR(INSTR),
    .OP_VALID(OP_VALID), .OP_READY(OP_READY),
    .OP_A(OP_A), .OP_B(OP_B), .OP_INSTR(OP_INSTR),
    .RESULT_VALID(RESULT_VALID), .RESULT(RESULT),
    .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
    .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
    .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
  );

  always #5 CLK = ~CLK;

  // Register-file model: drives read data only while RF_READ is high.
  logic [31:0] rf [32];
  assign RF_DATA_R1 = (RF_READ === 1'b1) ? rf[RF_ADDR_R1] : 'z;
  assign RF_DATA_R2 = (RF_READ === 1'b1) ? rf[RF_ADDR_R2] : 'z;
  always @(posedge CLK) if (RF_WRITE === 1'b1) rf[RF_ADDR_W] <= RF_DATA_W;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] instr; } op_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
  op_t op_q[$];
  wr_t wr_q[$];
  op_t mon_op;
  wr_t mon_wr;
  bit  ov_prev = 1'b0;

  // Scoreboard monitor: operands on the first OP_VALID cycle, writes on
  // every RF_WRITE cycle, and read/write exclusivity.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (OP_VALID === 1'b1 && !ov_prev) begin
        n_cmp++;
        if (op_q.size() == 0) begin
          n_err++;
          $display("FAIL op_unexpected: got A=%h B=%h I=%h, none expected", OP_A, OP_B, OP_INSTR);
        end else begin
          mon_op = op_q.pop_front();
          if ({OP_A, OP_B, OP_INSTR} !== {mon_op.a, mon_op.b, mon_op.instr}) begin
            n_err++;
            $display("FAIL operands: got A=%h B=%h I=%h, want A=%h B=%h I=%h",
                     OP_A, OP_B, OP_INSTR, mon_op.a, mon_op.b, mon_op.instr);
          end
        end
      end
      if (RF_WRITE === 1'b1) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL wb_unexpected: write r%0d=%h, none expected", RF_ADDR_W, RF_DATA_W);
        end else begin
          mon_wr = wr_q.pop_front();
          if ({RF_ADDR_W, RF_DATA_W} !== {mon_wr.addr, mon_wr.data}) begin
            n_err++;
            $display("FAIL wb_data: got r%0d=%h, want r%0d=%h",
                     RF_ADDR_W, RF_DATA_W, mon_wr.addr, mon_wr.data);
          end
        end
      end
      if (RF_READ === 1'b1 || RF_WRITE === 1'b1) begin
        n_cmp++;
        if (RF_READ === 1'b1 && RF_WRITE === 1'b1) begin
          n_err++;
          $display("FAIL rd_wr_excl: RF_READ=%b RF_WRITE=%b, want not both", RF_READ, RF_WRITE);
        end
      end
    end
    ov_prev = (OP_VALID === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one instruction and observes it until the DUT is ready again
  // (or max_k cycles). k counts negedges after the accept edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] result,
                       input int op_hold, input int res_hold, input int max_k,
                       output int wb_k, output int idle_k, output int ov_cycles,
                       output logic [4:0] r1, output logic [4:0] r2, output bit stable);
    int stalls = 0;
    int wait_cnt = 0;
    bit seen_ov = 1'b0;
    bit issued = 1'b0;
    logic [95:0] snap = '0;
    wb_k = -1; idle_k = -1; ov_cycles = 0; r1 = 'x; r2 = 'x; stable = 1'b1;
    for (int i = 0; i < 50 && INSTR_READY !== 1'b1; i++) @(negedge CLK);
    n_cmp++;
    if (INSTR_READY !== 1'b1) begin
      n_err++;
      $display("FAIL ready_timeout: INSTR_READY=%b, want 1", INSTR_READY);
    end
    #1;
    INSTR = instr; INSTR_VALID = 1'b1; RESULT = result;
    OP_READY = (op_hold == 0); RESULT_VALID = (res_hold == 0);
    @(posedge CLK);
    #1 INSTR_VALID = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge CLK);
      if (k == 1) begin r1 = RF_ADDR_R1; r2 = RF_ADDR_R2; end
      if (OP_VALID === 1'b1) begin
        if (!seen_ov) snap = {OP_A, OP_B, OP_INSTR};
        else if ({OP_A, OP_B, OP_INSTR} !== snap) stable = 1'b0;
        seen_ov = 1'b1;
        ov_cycles++;
        if (OP_READY !== 1'b1) begin
          stalls++;
          if (stalls > op_hold) #1 OP_READY = 1'b1;
        end
      end else if (seen_ov) issued = 1'b1;
      if (issued && RESULT_VALID !== 1'b1) begin
        wait_cnt++;
        if (wait_cnt >= res_hold) #1 RESULT_VALID = 1'b1;
      end
      if (RF_WRITE === 1'b1 && wb_k < 0) wb_k = k;
      if (INSTR_READY === 1'b1) begin idle_k = k; break; end
    end
  endtask

  int wb_k, idle_k, ov_c;
  logic [4:0] r1, r2;
  bit stable;

  task automatic test_reset();
    RST = 1'b0; INSTR_VALID = 1'b0; INSTR = '0; OP_READY = 1'b0;
    RESULT_VALID = 1'b0; RESULT = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({INSTR_READY, OP_VALID, RF_READ, RF_WRITE} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctrl: RDY/OPV/RD/WR=%b, want 1000", {INSTR_READY, OP_VALID, RF_READ, RF_WRITE});
    end
    n_cmp++;
    if ({RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_addr: R1=%0d R2=%0d W=%0d, want 0", RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W);
    end
    n_cmp++;
    if ({OP_A, OP_B, OP_INSTR, RF_DATA_W} !== 128'd0) begin
      n_err++;
      $display("FAIL reset_data: A=%h B=%h I=%h DW=%h, want 0", OP_A, OP_B, OP_INSTR, RF_DATA_W);
    end
  endtask

  task automatic test_rtype_add();
    op_q.push_back('{a: 32'd5, b: 32'd7, instr: 32'h0043_0820});
    wr_q.push_back('{addr: 5'd1, data: 32'd12});
    issue(32'h0043_0820, 32'd12, 0, 0, 20, wb_k, idle_k, ov_c, r1, r2, stable);
    n_cmp++;
    if ({r1, r2} !== {5'd2, 5'd3}) begin
      n_err++;
      $display("FAIL add_raddr: R1=%0d R2=%0d, want 2 3", r1, r2);
    end
    n_cmp++;
    if (wb_k !== 4) begin
      n_err++;
      $display("FAIL add_wb_latency: WB at cycle %0d, want 4", wb_k);
    end
    n_cmp++;
    if (idle_k !== 5) begin
      n_err++;
      $display("FAIL add_idle: ready at cycle %0d, want 5", idle_k);
    end
  endtask

  // Issued immediately after the add: reads r1 that the add just wrote.
  task automatic test_addi();
    op_q.push_back('{a: 32'd12, b: 32'hA000_0005, instr: 32'h2025_000A});
    wr_q.push_back('{addr: 5'd5, data: 32'd22});
    issue(32'h2025_000A, 32'd22, 0, 0, 20, wb_k, idle_k, ov_c, r1, r2, stable);
    n_cmp++;
    if ({r1, r2} !== {5'd1, 5'd5}) begin
      n_err++;
      $display("FAIL addi_raddr: R1=%0d R2=%0d, want 1 5", r1, r2);
    end
    n_cmp++;
    if (wb_k !== 4) begin
      n_err++;
      $display("FAIL addi_wb_latency: WB at cycle %0d, want 4", wb_k);
    end
  endtask

  task automatic test_jal();
    op_q.push_back('{a: R0_READ, b: R0_READ, instr: 32'h0C00_0010});
    wr_q.push_back('{addr: 5'd31, data: 32'h0000_0020});
    issue(32'h0C00_0010, 32'h0000_0020, 0, 0, 20, wb_k, idle_k, ov_c, r1, r2, stable);
    n_cmp++;
    if (wb_k !== 4) begin
      n_err++;
      $display("FAIL jal_wb_latency: WB at cycle %0d, want 4", wb_k);
    end
  endtask

  // sw, beq, bne, jmp, push, jr: no write-back, back to IDLE after WAIT_RES.
  task automatic test_no_write();
    logic [31:0] ins [6] = '{32'hAC22_0004, 32'h1022_0003, 32'h1422_0003,
                             32'h0800_0010, 32'h6C22_0000, 32'h03E0_0008};
    logic [31:0] ea  [6] = '{32'd12, 32'd12, 32'd12, R0_READ, 32'd12, 32'h20};
    logic [31:0] eb  [6] = '{32'd5, 32'd5, 32'd5, R0_READ, 32'd5, R0_READ};
    for (int i = 0; i < 6; i++) begin
      op_q.push_back('{a: ea[i], b: eb[i], instr: ins[i]});
      issue(ins[i], 32'hBAD0_0000 + i, 0, 0, 20, wb_k, idle_k, ov_c, r1, r2, stable);
      n_cmp++;
      if (wb_k !== -1 || idle_k !== 4) begin
        n_err++;
        $display("FAIL nowrite_%0d: wb=%0d idle=%0d for %h, want wb=-1 idle=4", i, wb_k, idle_k, ins[i]);
      end
    end
  endtask

  task automatic test_op_stall();
    op_q.push_back('{a: 32'd5, b: 32'd7, instr: 32'h0043_0820});
    wr_q.push_back('{addr: 5'd1, data: 32'h55});
    issue(32'h0043_0820, 32'h55, 3, 0, 30, wb_k, idle_k, ov_c, r1, r2, stable);
    n_cmp++;
    if (ov_c !== 4) begin
      n_err++;
      $display("FAIL stall_opvalid: OP_VALID for %0d cycles, want 4", ov_c);
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_err++;
      $display("FAIL stall_stable: operands stable=%b, want 1", stable);
    end
    n_cmp++;
    if (wb_k !== 7) begin
      n_err++;
      $display("FAIL stall_wb_latency: WB at cycle %0d, want 7", wb_k);
    end
  endtask

  // Write r7, then immediately read r7 twice from the next instruction.
  task automatic test_back_to_back();
    op_q.push_back('{a: 32'd5, b: 32'hA000_0007, instr: 32'h2047_0001});
    wr_q.push_back('{addr: 5'd7, data: 32'hCAFE_0001});
    issue(32'h2047_0001, 32'hCAFE_0001, 0, 0, 20, wb_k, idle_k, ov_c, r1, r2, stable);
    n_cmp++;
    if (idle_k !== 5) begin
      n_err++;
      $display("FAIL b2b_idle: ready at cycle %0d, want 5", idle_k);
    end
    op_q.push_back('{a: 32'hCAFE_0001, b: 32'hCAFE_0001, instr: 32'h00E7_4020});
    wr_q.push_back('{addr: 5'd8, data: 32'h1});
    issue(32'h00E7_4020, 32'h1, 0, 0, 20, wb_k, idle_k, ov_c, r1, r2, stable);
    n_cmp++;
    if (wb_k !== 4) begin
      n_err++;
      $display("FAIL b2b_wb_latency: WB at cycle %0d, want 4", wb_k);
    end
  endtask

  // add r0 = r0 + r2
  task automatic test_r0();
    int exp_wb, exp_idle;
    op_q.push_back('{a: R0_READ, b: 32'd5, instr: 32'h0002_0020});
`ifdef RF_R0_GUARD_EN
    exp_wb = -1; exp_idle = 4;
`else
    exp_wb = 4; exp_idle = 5;
    wr_q.push_back('{addr: 5'd0, data: 32'h77});
`endif
    issue(32'h0002_0020, 32'h77, 0, 0, 20, wb_k, idle_k, ov_c, r1, r2, stable);
    n_cmp++;
    if (wb_k !== exp_wb) begin
      n_err++;
      $display("FAIL r0_wb: WB at cycle %0d, want %0d", wb_k, exp_wb);
    end
    n_cmp++;
    if (idle_k !== exp_idle) begin
      n_err++;
      $display("FAIL r0_idle: ready at cycle %0d, want %0d", idle_k, exp_idle);
    end
  endtask

  // Park an add in WAIT_RES, then reset while RESULT_VALID rises.
  task automatic test_reset_mid_wait();
    int pulses = 0;
    op_q.push_back('{a: 32'd5, b: 32'd7, instr: 32'h0043_0820});
    issue(32'h0043_0820, 32'h99, 0, 1000, 6, wb_k, idle_k, ov_c, r1, r2, stable);
    n_cmp++;
    if (idle_k !== -1 || wb_k !== -1) begin
      n_err++;
      $display("FAIL rstmid_park: idle=%0d wb=%0d, want both -1", idle_k, wb_k);
    end
    #1 RST = 1'b0; RESULT_VALID = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({INSTR_READY, OP_VALID, RF_READ, RF_WRITE} !== 4'b1000) begin
      n_err++;
      $display("FAIL rstmid_ctrl: RDY/OPV/RD/WR=%b, want 1000", {INSTR_READY, OP_VALID, RF_READ, RF_WRITE});
    end
    n_cmp++;
    if ({RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, OP_A, OP_B, OP_INSTR, RF_DATA_W} !== 143'd0) begin
      n_err++;
      $display("FAIL rstmid_zero: R1=%0d R2=%0d W=%0d A=%h B=%h I=%h DW=%h, want 0",
               RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, OP_A, OP_B, OP_INSTR, RF_DATA_W);
    end
    for (int i = 0; i < 5; i++) begin
      if (RF_WRITE === 1'b1) pulses++;
      @(negedge CLK);
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL rstmid_nowrite: %0d RF_WRITE pulses, want 0", pulses);
    end
    RESULT_VALID = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | i;
    rf[0] = 32'hDEAD_0000;
    rf[2] = 32'd5;
    rf[3] = 32'd7;

    test_reset();
    test_rtype_add();
    test_addi();
    test_jal();
    test_no_write();
    test_op_stall();
    test_back_to_back();
    test_r0();
    test_reset_mid_wait();

    n_cmp++;
    if (op_q.size() != 0 || wr_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d operand / %0d write expectations left, want 0",
               op_q.size(), wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
